// File: rtl/uart_slv_pkg.sv
// Shared constants and types for the AXI4-Lite UART-Lite responder.
package uart_slv_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;

    // Register selects, taken from address bits [3:2]
    localparam logic [1:0] REG_RX   = 2'd0;
    localparam logic [1:0] REG_TX   = 2'd1;
    localparam logic [1:0] REG_STAT = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    // STAT register bit positions
    localparam int unsigned STAT_RX_VALID = 0;
    localparam int unsigned STAT_RX_FULL  = 1;
    localparam int unsigned STAT_TX_EMPTY = 2;
    localparam int unsigned STAT_TX_FULL  = 3;
    localparam int unsigned STAT_OVERRUN  = 5;

    // CTRL register bit positions
    localparam int unsigned CTRL_TX_CLR = 0;
    localparam int unsigned CTRL_RX_CLR = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // Assemble the STAT word from individual flags
    function automatic logic [DATA_W-1:0] pack_stat(
        input logic rx_not_empty,
        input logic rx_full,
        input logic tx_empty,
        input logic tx_full,
        input logic overrun
    );
        logic [DATA_W-1:0] s;
        s                = '0;
        s[STAT_RX_VALID] = rx_not_empty;
        s[STAT_RX_FULL]  = rx_full;
        s[STAT_TX_EMPTY] = tx_empty;
        s[STAT_TX_FULL]  = tx_full;
        s[STAT_OVERRUN]  = overrun;
        return s;
    endfunction

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO; pop is evaluated before push so a full FIFO
// accepts a push in the same cycle it is popped. Clear overrides both.
module sync_byte_fifo
    import uart_slv_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [BYTE_W-1:0]        push_data,
    input  logic                     pop,
    output logic [BYTE_W-1:0]        head_c,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic [BYTE_W-1:0] mem_q [DEPTH];

    logic pop_eff_c;
    logic push_eff_c;

    assign pop_eff_c  = pop && !empty_q;
    assign push_eff_c = push && (!full_q || pop_eff_c);

    // Next pointer/count/flag state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_eff_c) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_eff_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_eff_c) - CNT_W'(pop_eff_c);
        end
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Pointer/count/flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array; contents need no reset since they are guarded by count
    always_ff @(posedge clk) begin
        if (push_eff_c && !clear) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_c = mem_q[rd_ptr_q];
    assign count  = count_q;
    assign full   = full_q;
    assign empty  = empty_q;

endmodule

// File: rtl/axi_uart_lite_slave.sv
// AXI4-Lite UART-Lite register block: RX/TX byte FIFOs behind RX, TX,
// STAT and CTRL registers. Define UART_SLV_LOOPBACK_EN to route the TX
// FIFO head straight into the RX FIFO and silence the byte-stream ports.
module axi_uart_lite_slave
    import uart_slv_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ADDR_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [7:0]        rx_in_data,
    input  logic              rx_in_valid,
    output logic [7:0]        tx_out_data,
    output logic              tx_out_valid,
    input  logic              tx_out_ready
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    // FIFO interface
    logic [BYTE_W-1:0] rx_head_c, tx_head_c;
    logic [CNT_W-1:0]  rx_count, tx_count;
    logic              rx_full, rx_empty, tx_full, tx_empty;
    logic              rx_push_c, rx_pop_c, rx_clear_c;
    logic              tx_push_c, tx_pop_c, tx_clear_c;
    logic [BYTE_W-1:0] rx_push_data_c;

    // Read channel state
    rd_state_t         rd_state_q, rd_state_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              overrun_q, overrun_d;
    logic              ar_hs_c;
    logic [1:0]        rd_sel_c;
    logic [DATA_W-1:0] rd_word_c;

    // Write channel state
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [1:0]        wr_sel_q, wr_sel_d;
    logic [BYTE_W-1:0] wbyte_q, wbyte_d;
    logic              wstrb0_q, wstrb0_d;
    logic              aw_hs_c, w_hs_c, commit_c, tx_accept_c;

    logic              unused_c;

    sync_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (rx_clear_c),
        .push      (rx_push_c),
        .push_data (rx_push_data_c),
        .pop       (rx_pop_c),
        .head_c    (rx_head_c),
        .count     (rx_count),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    sync_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (tx_clear_c),
        .push      (tx_push_c),
        .push_data (wbyte_q),
        .pop       (tx_pop_c),
        .head_c    (tx_head_c),
        .count     (tx_count),
        .full      (tx_full),
        .empty     (tx_empty)
    );

`ifdef UART_SLV_LOOPBACK_EN
    // Internal loopback: move one byte per cycle from TX head into RX
    assign rx_push_c      = !tx_empty && !rx_full;
    assign rx_push_data_c = tx_head_c;
    assign tx_pop_c       = !tx_empty && !rx_full;
    assign tx_out_valid   = 1'b0;
    assign tx_out_data    = tx_head_c;
`else
    // Byte-stream ports connect directly to the FIFOs
    assign rx_push_c      = rx_in_valid;
    assign rx_push_data_c = rx_in_data;
    assign tx_pop_c       = tx_out_ready && !tx_empty;
    assign tx_out_valid   = !tx_empty;
    assign tx_out_data    = tx_head_c;
`endif

    // Read address decode and data selection
    always_comb begin
        rd_sel_c  = s_axi_araddr[3:2];
        ar_hs_c   = s_axi_arvalid && arready_q;
        rd_word_c = '0;
        case (rd_sel_c)
            REG_RX: begin
                if (!rx_empty) begin
                    rd_word_c = {24'd0, rx_head_c};
                end
            end
            REG_STAT: rd_word_c = pack_stat(!rx_empty, rx_full, tx_empty, tx_full, overrun_q);
            default:  rd_word_c = '0;
        endcase
        rx_pop_c = ar_hs_c && (rd_sel_c == REG_RX) && !rx_empty;
    end

    // Read FSM next state and outputs
    always_comb begin
        rd_state_d = rd_state_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        case (rd_state_q)
            R_IDLE: begin
                if (ar_hs_c) begin
                    rd_state_d = R_DATA;
                    arready_d  = 1'b0;
                    rvalid_d   = 1'b1;
                    rdata_d    = rd_word_c;
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    rd_state_d = R_IDLE;
                    arready_d  = 1'b1;
                    rvalid_d   = 1'b0;
                end
            end
            default: begin
                rd_state_d = R_IDLE;
                arready_d  = 1'b1;
                rvalid_d   = 1'b0;
            end
        endcase
    end

    // Sticky overrun: cleared by a STAT read, a fresh drop in the same cycle wins
    always_comb begin
        overrun_d = overrun_q;
        if (ar_hs_c && (rd_sel_c == REG_STAT)) begin
            overrun_d = 1'b0;
        end
        if (rx_push_c && rx_full && !rx_pop_c && !rx_clear_c) begin
            overrun_d = 1'b1;
        end
    end

    // Write channel: independent AW/W capture, commit once both are held
    always_comb begin
        awready_d   = awready_q;
        wready_d    = wready_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        wr_sel_d    = wr_sel_q;
        wbyte_d     = wbyte_q;
        wstrb0_d    = wstrb0_q;
        aw_hs_c     = s_axi_awvalid && awready_q;
        w_hs_c      = s_axi_wvalid && wready_q;
        commit_c    = !awready_q && !wready_q && !bvalid_q;
        tx_accept_c = !tx_full || tx_pop_c;
        tx_push_c   = 1'b0;
        tx_clear_c  = 1'b0;
        rx_clear_c  = 1'b0;
        if (aw_hs_c) begin
            awready_d = 1'b0;
            wr_sel_d  = s_axi_awaddr[3:2];
        end
        if (w_hs_c) begin
            wready_d = 1'b0;
            wbyte_d  = s_axi_wdata[7:0];
            wstrb0_d = s_axi_wstrb[0];
        end
        if (commit_c) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_OKAY;
            if (wstrb0_q) begin
                case (wr_sel_q)
                    REG_TX: begin
                        if (tx_accept_c) begin
                            tx_push_c = 1'b1;
                        end else begin
                            bresp_d = RESP_SLVERR;
                        end
                    end
                    REG_CTRL: begin
                        tx_clear_c = wbyte_q[CTRL_TX_CLR];
                        rx_clear_c = wbyte_q[CTRL_RX_CLR];
                    end
                    default: ;
                endcase
            end
        end
        if (bvalid_q && s_axi_bready) begin
            bvalid_d  = 1'b0;
            awready_d = 1'b1;
            wready_d  = 1'b1;
        end
    end

    // All AXI-side registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            overrun_q  <= 1'b0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_sel_q   <= '0;
            wbyte_q    <= '0;
            wstrb0_q   <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            overrun_q  <= overrun_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_sel_q   <= wr_sel_d;
            wbyte_q    <= wbyte_d;
            wstrb0_q   <= wstrb0_d;
        end
    end

    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = RESP_OKAY;
    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;

    // Inputs and status deliberately left unconsumed
    assign unused_c = ^{s_axi_araddr, s_axi_awaddr, s_axi_wdata[31:8], s_axi_wstrb[3:1],
                        rx_count, tx_count, rx_in_data, rx_in_valid, tx_out_ready};

endmodule

// File: tb/tb_axi_uart_lite_slave.sv
// Directed scoreboard bench for axi_uart_lite_slave (default build).
module tb_axi_uart_lite_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [3:0]  s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [7:0]  rx_in_data;
    logic        rx_in_valid;
    logic [7:0]  tx_out_data;
    logic        tx_out_valid;
    logic        tx_out_ready;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rd_exp_q[$];
    logic [1:0]  wr_exp_q[$];
    logic [7:0]  tx_exp_q[$];

    axi_uart_lite_slave #(.FIFO_DEPTH(8), .ADDR_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .rx_in_data    (rx_in_data),
        .rx_in_valid   (rx_in_valid),
        .tx_out_data   (tx_out_data),
        .tx_out_valid  (tx_out_valid),
        .tx_out_ready  (tx_out_ready)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        failures++;
        $error("FAIL %s observed=timeout expected=handshake", tag);
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_in_data  = b;
        rx_in_valid = 1'b1;
        step();
        rx_in_valid = 1'b0;
    endtask

    // AXI read; optionally pulses rx_in_valid in the address-handshake cycle
    task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp, input string tag,
                            input bit rx_strobe, input logic [7:0] rx_byte);
        int n;
        logic [31:0] e;
        rd_exp_q.push_back(exp);
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        s_axi_rready  = 1'b1;
        n = 0;
        while (!s_axi_arready && n < 50) begin
            step();
            n++;
        end
        if (!s_axi_arready) begin
            s_axi_arvalid = 1'b0;
            void'(rd_exp_q.pop_back());
            timeout_fail({tag, "_arready"});
            return;
        end
        if (rx_strobe) begin
            rx_in_data  = rx_byte;
            rx_in_valid = 1'b1;
        end
        step();
        s_axi_arvalid = 1'b0;
        rx_in_valid   = 1'b0;
        n = 0;
        while (!s_axi_rvalid && n < 50) begin
            step();
            n++;
        end
        if (!s_axi_rvalid) begin
            void'(rd_exp_q.pop_back());
            timeout_fail({tag, "_rvalid"});
            s_axi_rready = 1'b0;
            return;
        end
        e = rd_exp_q.pop_front();
        chk(tag, s_axi_rdata, e);
        chk({tag, "_rresp"}, 32'(s_axi_rresp), 32'd0);
        step();
        s_axi_rready = 1'b0;
    endtask

    // AXI write with AW and W presented together
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [1:0] exp_resp, input string tag);
        int n;
        bit aw_hs, w_hs;
        wr_exp_q.push_back(exp_resp);
        s_axi_awaddr  = addr;
        s_axi_awvalid = 1'b1;
        s_axi_wdata   = data;
        s_axi_wstrb   = strb;
        s_axi_wvalid  = 1'b1;
        s_axi_bready  = 1'b1;
        n = 0;
        while ((s_axi_awvalid || s_axi_wvalid) && n < 50) begin
            aw_hs = s_axi_awvalid && s_axi_awready;
            w_hs  = s_axi_wvalid && s_axi_wready;
            step();
            if (aw_hs) s_axi_awvalid = 1'b0;
            if (w_hs)  s_axi_wvalid  = 1'b0;
            n++;
        end
        n = 0;
        while (!s_axi_bvalid && n < 50) begin
            step();
            n++;
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        if (!s_axi_bvalid) begin
            void'(wr_exp_q.pop_back());
            timeout_fail({tag, "_bvalid"});
            s_axi_bready = 1'b0;
            return;
        end
        chk({tag, "_bresp"}, 32'(s_axi_bresp), 32'(wr_exp_q.pop_front()));
        step();
        s_axi_bready = 1'b0;
    endtask

    // Drain the TX FIFO and compare against the expected byte queue
    task automatic tx_drain(input string tag);
        int n;
        logic [7:0] e;
        tx_out_ready = 1'b1;
        n = 0;
        while (tx_exp_q.size() > 0 && n < 100) begin
            if (tx_out_valid) begin
                e = tx_exp_q.pop_front();
                chk(tag, 32'(tx_out_data), 32'(e));
            end
            step();
            n++;
        end
        tx_out_ready = 1'b0;
        if (tx_exp_q.size() != 0) begin
            timeout_fail({tag, "_drain"});
            tx_exp_q.delete();
        end
        chk({tag, "_empty"}, 32'(tx_out_valid), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        s_axi_araddr  = '0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        s_axi_awaddr  = '0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wstrb   = 4'hF;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b0;
        rx_in_data    = '0;
        rx_in_valid   = 1'b0;
        tx_out_ready  = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_arready", 32'(s_axi_arready), 32'd1);
        chk("rst_awready", 32'(s_axi_awready), 32'd1);
        chk("rst_wready",  32'(s_axi_wready),  32'd1);
        chk("rst_rvalid",  32'(s_axi_rvalid),  32'd0);
        chk("rst_bvalid",  32'(s_axi_bvalid),  32'd0);
        chk("rst_rdata",   s_axi_rdata,        32'd0);
        chk("rst_bresp",   32'(s_axi_bresp),   32'd0);
        chk("rst_txvalid", 32'(tx_out_valid),  32'd0);

        // RX push and pop order
        rx_push(8'h41);
        rx_push(8'h42);
        axi_read(4'h8, 32'h5,  "stat_two_rx", 1'b0, 8'h00);
        axi_read(4'h0, 32'h41, "rx_pop1",     1'b0, 8'h00);
        axi_read(4'h0, 32'h42, "rx_pop2",     1'b0, 8'h00);
        axi_read(4'h8, 32'h4,  "stat_idle",   1'b0, 8'h00);
        axi_read(4'h0, 32'h0,  "rx_empty_rd", 1'b0, 8'h00);
        axi_read(4'hB, 32'h4,  "stat_alias",  1'b0, 8'h00);
        axi_read(4'hC, 32'h0,  "ctrl_rd",     1'b0, 8'h00);

        // AW two cycles ahead of W
        wr_exp_q.push_back(2'b00);
        s_axi_awaddr  = 4'h4;
        s_axi_awvalid = 1'b1;
        s_axi_bready  = 1'b0;
        step();
        s_axi_awvalid = 1'b0;
        chk("aw_first_awready", 32'(s_axi_awready), 32'd0);
        step();
        s_axi_wdata  = 32'h0000_0055;
        s_axi_wstrb  = 4'h1;
        s_axi_wvalid = 1'b1;
        step();
        s_axi_wvalid = 1'b0;
        chk("aw_first_bvalid_hs", 32'(s_axi_bvalid), 32'd0);
        step();
        chk("aw_first_bvalid", 32'(s_axi_bvalid), 32'd1);
        chk("aw_first_bresp", 32'(s_axi_bresp), 32'(wr_exp_q.pop_front()));
        s_axi_bready = 1'b1;
        step();
        s_axi_bready = 1'b0;
        chk("aw_first_ready_back", 32'({s_axi_awready, s_axi_wready}), 32'd3);
        chk("tx_head",  32'(tx_out_data),  32'h55);
        chk("tx_valid", 32'(tx_out_valid), 32'd1);
        tx_exp_q.push_back(8'h55);
        tx_drain("tx_single");

        // Fill TX past capacity
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                tx_exp_q.push_back(8'(8'hA0 + i));
                axi_write(4'h4, 32'(8'hA0 + i), 4'hF, 2'b00, "tx_fill");
            end else begin
                axi_write(4'h4, 32'hEE, 4'hF, 2'b10, "tx_overflow");
            end
        end
        axi_read(4'h8, 32'h8, "stat_tx_full", 1'b0, 8'h00);
        tx_drain("tx_order");
        axi_write(4'h4, 32'h33, 4'h0, 2'b00, "tx_nostrb");
        axi_read(4'h8, 32'h4, "stat_nostrb", 1'b0, 8'h00);

        // RX overrun with a byte parked in TX
        tx_exp_q.push_back(8'h77);
        axi_write(4'h4, 32'h77, 4'h1, 2'b00, "tx_park");
        for (int i = 0; i < 9; i++) begin
            rx_push(8'(8'h10 + i));
        end
        axi_read(4'h8, 32'h23, "stat_overrun",    1'b0, 8'h00);
        axi_read(4'h8, 32'h03, "stat_overrun_clr", 1'b0, 8'h00);

        // Simultaneous push and pop on a full RX FIFO
        axi_read(4'h0, 32'h10, "rx_full_pushpop", 1'b1, 8'hAA);
        axi_read(4'h8, 32'h03, "stat_full_pushpop", 1'b0, 8'h00);
        axi_read(4'h0, 32'h11, "rx_after_pushpop", 1'b0, 8'h00);
        axi_write(4'hC, 32'h2, 4'h1, 2'b00, "ctrl_rx_clr");
        axi_read(4'h8, 32'h00, "stat_rx_clr", 1'b0, 8'h00);
        tx_drain("tx_parked");
        axi_read(4'h8, 32'h04, "stat_clean", 1'b0, 8'h00);

        // Reset while read data is pending
        rx_push(8'h99);
        s_axi_araddr  = 4'h8;
        s_axi_arvalid = 1'b1;
        s_axi_rready  = 1'b0;
        step();
        s_axi_arvalid = 1'b0;
        chk("pend_rvalid", 32'(s_axi_rvalid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_rvalid",  32'(s_axi_rvalid),  32'd0);
        chk("rst_mid_arready", 32'(s_axi_arready), 32'd1);
        step();
        axi_read(4'h8, 32'h4, "stat_after_rst", 1'b0, 8'h00);

        chk("rd_queue_empty", 32'(rd_exp_q.size()), 32'd0);
        chk("wr_queue_empty", 32'(wr_exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
